// File: rtl/approx_add_pkg.sv
// Shared constants and helpers for the pipelined approximate adder.
// The low-field helper is used by both the datapath and any reference model.
package approx_add_pkg;
  localparam int   DEF_WIDTH     = 8;
  localparam int   DEF_FILL_BITS = 3;
  localparam int   DEF_PASS_BITS = 1;
  localparam logic DEF_FILL_VAL  = 1'b1;
  localparam int   DEF_SEG_BITS  = 4;
  localparam int   MAXW          = 64;

  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // Fill bits at the bottom, then pass bits copied from A; everything above is zero.
  function automatic logic [MAXW-1:0] lowfield(input logic [MAXW-1:0] a, input int fill_bits,
                                               input int pass_bits, input logic fill_val);
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < fill_bits)                  r[i] = fill_val;
      else if (i < fill_bits + pass_bits) r[i] = a[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/approx_add_seg.sv
// One carry-chain pipeline stage: adds its operand segment, registers the
// partial result and forwards the rest of the transaction. The last stage applies the low field.
module approx_add_seg #(
  parameter int WIDTH    = 8,
  parameter int SEG_BITS = 4,
  parameter int IDX      = 0,
  parameter bit LAST     = 1'b0,
  parameter int L        = 4,
  parameter int LW       = 4,
  parameter int TW       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH:0]   i_sum,
  input  logic             i_cy,
  input  logic [LW-1:0]    i_low,
  input  logic             i_exact,
  input  logic [TW-1:0]    i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH:0]   o_sum,
  output logic             o_cy,
  output logic [LW-1:0]    o_low,
  output logic             o_exact,
  output logic [TW-1:0]    o_tag
);
  localparam int LO = IDX * SEG_BITS;
  localparam int SW = LAST ? (WIDTH - LO) : SEG_BITS;

  logic [SW:0]    w_seg;
  logic [WIDTH:0] w_sum;
  logic           r_valid, r_cy, r_exact;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH:0] r_sum;
  logic [LW-1:0]  r_low;
  logic [TW-1:0]  r_tag;

  assign w_seg = {1'b0, i_a[LO +: SW]} + {1'b0, i_b[LO +: SW]} + {{SW{1'b0}}, i_cy};

  always_comb begin
    w_sum = i_sum;
    w_sum[LO +: SW] = w_seg[SW-1:0];
    if (LAST) begin
      w_sum[WIDTH] = w_seg[SW];
      if (L > 0 && !i_exact) w_sum[LW-1:0] = i_low;
    end
  end

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cy    <= 1'b0;
      r_low   <= '0;
      r_exact <= 1'b0;
      r_tag   <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_sum   <= w_sum;
        r_cy    <= w_seg[SW];
        r_low   <= i_low;
        r_exact <= i_exact;
        r_tag   <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_sum   = r_sum;
  assign o_cy    = r_cy;
  assign o_low   = r_low;
  assign o_exact = r_exact;
  assign o_tag   = r_tag;
endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder with valid/ready flow control.
// Define APPROX_ADD_ERRSTAT_EN to add error statistics ports and counters.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   FILL_BITS = DEF_FILL_BITS,
  parameter int   PASS_BITS = DEF_PASS_BITS,
  parameter logic FILL_VAL  = DEF_FILL_VAL,
  parameter int   SEG_BITS  = DEF_SEG_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_exact
`ifdef APPROX_ADD_ERRSTAT_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_cnt,
  output logic [31:0]      stat_err_sum,
  output logic [WIDTH:0]   stat_err_max
`endif
);
  localparam int L    = FILL_BITS + PASS_BITS;
  localparam int NSEG = nseg(WIDTH, SEG_BITS);
  localparam int LW   = (L > 0) ? L : 1;
  localparam int TW   = L + 1;
  localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} << L;

  if (FILL_BITS < 0 || PASS_BITS < 0 || L > WIDTH || SEG_BITS < 1 || WIDTH > MAXW) begin : g_illegal
    $error("approx_add_pipe: illegal parameter combination");
  end

  logic [NSEG:0]             vld_pipe, rdy_pipe, w_cy, w_exact;
  logic [NSEG:0][WIDTH-1:0]  w_a, w_b;
  logic [NSEG:0][WIDTH:0]    w_sum;
  logic [NSEG:0][LW-1:0]     w_low;
  logic [NSEG:0][TW-1:0]     w_tag;

  // Masking the low L bits of both operands guarantees no carry into the exact part.
  assign vld_pipe[0] = in_valid;
  assign in_ready    = rdy_pipe[0];
  assign rdy_pipe[NSEG] = out_ready;
  assign w_a[0]      = in_exact ? in_a : (in_a & MASK);
  assign w_b[0]      = in_exact ? in_b : (in_b & MASK);
  assign w_sum[0]    = '0;
  assign w_cy[0]     = 1'b0;
  assign w_low[0]    = LW'(lowfield(MAXW'(in_a), FILL_BITS, PASS_BITS, FILL_VAL));
  assign w_exact[0]  = in_exact;

`ifdef APPROX_ADD_ERRSTAT_EN
  if (L > 0) begin : g_diff
    logic [TW:0] w_diff, w_neg;
    assign w_diff   = {2'b00, in_a[LW-1:0]} + {2'b00, in_b[LW-1:0]} - {2'b00, w_low[0]};
    assign w_neg    = -w_diff;
    assign w_tag[0] = in_exact ? '0 : (w_diff[TW] ? w_neg[TW-1:0] : w_diff[TW-1:0]);
  end else begin : g_nodiff
    assign w_tag[0] = '0;
  end
`else
  assign w_tag[0] = '0;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    approx_add_seg #(
      .WIDTH(WIDTH), .SEG_BITS(SEG_BITS), .IDX(k), .LAST(k == NSEG - 1),
      .L(L), .LW(LW), .TW(TW)
    ) u_seg (
      .clk(clk), .rst_n(rst_n),
      .i_valid(vld_pipe[k]), .o_ready(rdy_pipe[k]),
      .i_a(w_a[k]), .i_b(w_b[k]), .i_sum(w_sum[k]), .i_cy(w_cy[k]),
      .i_low(w_low[k]), .i_exact(w_exact[k]), .i_tag(w_tag[k]),
      .o_valid(vld_pipe[k+1]), .i_ready(rdy_pipe[k+1]),
      .o_a(w_a[k+1]), .o_b(w_b[k+1]), .o_sum(w_sum[k+1]), .o_cy(w_cy[k+1]),
      .o_low(w_low[k+1]), .o_exact(w_exact[k+1]), .o_tag(w_tag[k+1])
    );
  end

  assign out_valid = vld_pipe[NSEG];
  assign out_sum   = w_sum[NSEG];
  assign out_exact = w_exact[NSEG];

`ifdef APPROX_ADD_ERRSTAT_EN
  logic           w_hs;
  logic [32:0]    w_err_nx;
  logic [WIDTH:0] w_tag_ext;
  logic [31:0]    r_cnt, r_err_sum;
  logic [WIDTH:0] r_err_max;

  assign w_hs      = out_valid && out_ready;
  assign w_tag_ext = (WIDTH+1)'(w_tag[NSEG]);
  assign w_err_nx  = {1'b0, r_err_sum} + 33'(w_tag[NSEG]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (stat_clr) begin
      r_cnt     <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_hs) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
      r_err_sum <= w_err_nx[32] ? '1 : w_err_nx[31:0];
      if (w_tag_ext > r_err_max) r_err_max <= w_tag_ext;
    end
  end

  assign stat_cnt     = r_cnt;
  assign stat_err_sum = r_err_sum;
  assign stat_err_max = r_err_max;

  logic w_unused;
  assign w_unused = ^{w_a[NSEG], w_b[NSEG], w_cy[NSEG], w_low[NSEG]};
`else
  logic w_unused;
  assign w_unused = ^{w_a[NSEG], w_b[NSEG], w_cy[NSEG], w_low[NSEG], w_tag[NSEG]};
`endif
endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe: default configuration plus a 7-bit, 3-bit-segment, L=0 instance.
module tb_approx_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_exact, out_ready;
  logic       in_ready, out_valid, out_exact;
  logic [7:0] in_a, in_b;
  logic [8:0] out_sum;

  logic       s7_in_valid, s7_in_exact, s7_out_ready;
  logic       s7_in_ready, s7_out_valid, s7_out_exact;
  logic [6:0] s7_in_a, s7_in_b;
  logic [7:0] s7_out_sum;

`ifdef APPROX_ADD_ERRSTAT_EN
  logic        stat_clr, s7_stat_clr;
  logic [31:0] stat_cnt, stat_err_sum, s7_stat_cnt, s7_stat_err_sum;
  logic [8:0]  stat_err_max;
  logic [7:0]  s7_stat_err_max;
`endif

  approx_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_exact(out_exact)
`ifdef APPROX_ADD_ERRSTAT_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_err_sum(stat_err_sum),
    .stat_err_max(stat_err_max)
`endif
  );

  approx_add_pipe #(.WIDTH(7), .FILL_BITS(0), .PASS_BITS(0), .SEG_BITS(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(s7_in_valid), .in_ready(s7_in_ready),
    .in_a(s7_in_a), .in_b(s7_in_b), .in_exact(s7_in_exact), .out_valid(s7_out_valid),
    .out_ready(s7_out_ready), .out_sum(s7_out_sum), .out_exact(s7_out_exact)
`ifdef APPROX_ADD_ERRSTAT_EN
    , .stat_clr(s7_stat_clr), .stat_cnt(s7_stat_cnt), .stat_err_sum(s7_stat_err_sum),
    .stat_err_max(s7_stat_err_max)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_exact = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    s7_in_valid = 1'b0; s7_in_exact = 1'b0; s7_out_ready = 1'b1; s7_in_a = '0; s7_in_b = '0;
`ifdef APPROX_ADD_ERRSTAT_EN
    stat_clr = 1'b0; s7_stat_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'h000);
    chk("rst_out_exact", 32'(out_exact), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef APPROX_ADD_ERRSTAT_EN
    chk("rst_stat_cnt",  stat_cnt,       32'd0);
`endif
    rst_n = 1'b1;

    // basic approximate transaction, 2-cycle latency
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h33; in_exact = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat2_out_valid", 32'(out_valid), 32'd1);
    chk("approx_5A_33",   32'(out_sum),   32'h08F);
    chk("approx_exact",   32'(out_exact), 32'd0);

    // worst case approximate then exact, back to back
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_exact = 1'b0;
    tick();
    in_exact = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("approx_FF_FF", 32'(out_sum),   32'h1EF);
    chk("approx_FF_ex", 32'(out_exact), 32'd0);
    tick();
    chk("exact_FF_FF",  32'(out_sum),   32'h1FE);
    chk("exact_FF_ex",  32'(out_exact), 32'd1);
    tick();
    chk("drain_valid",  32'(out_valid), 32'd0);

    // back-pressure: pipeline fills with two, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_exact = 1'b1;
    tick();
    in_a = 8'h0C; in_b = 8'h04; in_exact = 1'b0;
    tick();
    chk("bp_in_ready_lo",  32'(in_ready),  32'd0);
    chk("bp_out_valid",    32'(out_valid), 32'd1);
    chk("bp_sum0",         32'(out_sum),   32'h030);
    in_a = 8'h80; in_b = 8'h80; in_exact = 1'b1;
    tick();
    chk("bp_sum0_stable",  32'(out_sum),   32'h030);
    chk("bp_in_ready_lo2", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    tick();
    chk("bp_sum1",       32'(out_sum),   32'h00F);
    chk("bp_sum1_exact", 32'(out_exact), 32'd0);
    in_a = 8'hA5; in_b = 8'h5A; in_exact = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("bp_sum2",       32'(out_sum),   32'h100);
    tick();
    chk("bp_sum3",       32'(out_sum),   32'h0F7);
    tick();
    chk("bp_drained",    32'(out_valid), 32'd0);

    // reset with two transactions in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_exact = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum",   32'(out_sum),   32'h000);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_no_stale", 32'(out_valid), 32'd0);

    // odd width, L = 0, three stages
    s7_in_valid = 1'b1; s7_in_a = 7'h7F; s7_in_b = 7'h01; s7_in_exact = 1'b0;
    tick();
    s7_in_valid = 1'b0;
    tick();
    chk("w7_lat2_valid", 32'(s7_out_valid), 32'd0);
    tick();
    chk("w7_lat3_valid", 32'(s7_out_valid), 32'd1);
    chk("w7_sum",        32'(s7_out_sum),   32'h080);

`ifdef APPROX_ADD_ERRSTAT_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st_pre_cnt", stat_cnt, 32'd0);
    in_valid = 1'b1; in_exact = 1'b0; in_a = 8'h08; in_b = 8'h05;
    tick();
    in_a = 8'hFF; in_b = 8'hFF;
    tick();
    in_a = 8'h0F; in_b = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("st_cnt", stat_cnt,               32'd3);
    chk("st_sum", stat_err_sum,           32'd17);
    chk("st_max", 32'(stat_err_max),      32'd15);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st_clr_cnt", stat_cnt,           32'd0);
    chk("st_clr_sum", stat_err_sum,       32'd0);
    chk("st_clr_max", 32'(stat_err_max),  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
